// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared types and constants for the memory-stage load/store unit.
//   load_funct3_e  : RV32I load funct3 encodings (LB, LH, LW, LBU, LHU)
//   store_funct3_e : RV32I store funct3 encodings (SB, SH, SW)
//   lsu_state_e    : handshake FSM states (IDLE, WAIT)
//   BE_*           : byte-enable base patterns, shifted into place by offset
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  // Loads and stores reuse the same funct3 values, so they live in two enums.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align -- combinational load formatter.
// Selects the byte/halfword lane of a raw memory word by the access offset
// and sign- or zero-extends it according to the load funct3.
//   raw_i    in  32  raw word from data memory
//   funct3_i in  3   load funct3
//   off_i    in  2   byte offset of the access (addr[1:0])
//   data_o   out 32  formatted load data (0 for unknown funct3)
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] raw_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension
  always_comb begin
    byte_s = raw_i[{off_i, 3'b000} +: 8];
    // Halfword lane uses only addr[1]; addr[0] is ignored by design.
    half_s = off_i[1] ? raw_i[31:16] : raw_i[15:0];
    case (funct3_i)
      LB:      data_o = {{24{byte_s[7]}}, byte_s};
      LH:      data_o = {{16{half_s[15]}}, half_s};
      LW:      data_o = raw_i;
      LBU:     data_o = {24'h000000, byte_s};
      LHU:     data_o = {16'h0000, half_s};
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- memory-stage load/store unit of the RV32I pipeline.
// Turns MEM-stage load/store control into a req/gnt/rvalid data-memory
// transaction and returns formatted load data, stalling the pipeline until
// the access completes.
// Ports:
//   CLK, RSTn              clock, synchronous active-low reset
//   MemReadM, MemWriteM    load / store in the memory stage (mutually exclusive)
//   Funct3M                access size and sign
//   ALUResultM             effective byte address
//   WriteDataM             store source value
//   ReadDataM              formatted load data (held between loads)
//   StallM                 freeze the upstream pipeline registers
//   MisalignM              misaligned access flag (only with LSU_MISALIGN_CHK_EN)
//   DMemReq/We/Addr/Be/WData  request side of the data-memory port
//   DMemGnt, DMemRValid, DMemRData  response side of the data-memory port
// Configuration macro: LSU_MISALIGN_CHK_EN -- when defined, misaligned
// halfword/word accesses are flagged and suppressed instead of issued.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic [2:0]       Funct3M,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  output logic [WIDTH-1:0] ReadDataM,
  output logic             StallM,
`ifdef LSU_MISALIGN_CHK_EN
  output logic             MisalignM,
`endif
  output logic             DMemReq,
  output logic             DMemWe,
  output logic [WIDTH-1:0] DMemAddr,
  output logic [3:0]       DMemBe,
  output logic [WIDTH-1:0] DMemWData,
  input  logic             DMemGnt,
  input  logic             DMemRValid,
  input  logic [WIDTH-1:0] DMemRData
);

  lsu_state_e       state_q, state_d;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [WIDTH-1:0] raw_q;

  logic             access_s;
  logic             misalign_s;
  logic             load_grant_s;
  logic             rvalid_take_s;
  logic [3:0]       store_be_s;
  logic [WIDTH-1:0] store_wdata_s;
  logic [WIDTH-1:0] align_raw_s;
  logic [WIDTH-1:0] align_data_s;

  assign access_s      = MemReadM | MemWriteM;
  assign rvalid_take_s = (state_q == ST_WAIT) & DMemRValid;

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign_s = ((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                      ((Funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00));
  assign MisalignM  = RSTn & (state_q == ST_IDLE) & access_s & misalign_s;
`else
  assign misalign_s = 1'b0;
`endif

  // Store byte enables and lane-replicated write data
  always_comb begin
    store_be_s    = BE_NONE;
    store_wdata_s = WriteDataM;
    case (Funct3M)
      SB: begin
        store_be_s    = BE_BYTE << ALUResultM[1:0];
        store_wdata_s = {4{WriteDataM[7:0]}};
      end
      SH: begin
        store_be_s    = BE_HALF << {ALUResultM[1], 1'b0};
        store_wdata_s = {2{WriteDataM[15:0]}};
      end
      SW: begin
        store_be_s    = BE_WORD;
        store_wdata_s = WriteDataM;
      end
      default: begin
        store_be_s    = BE_NONE;
        store_wdata_s = WriteDataM;
      end
    endcase
  end

  // The arriving word is formatted directly so data is usable in the rvalid cycle
  assign align_raw_s = rvalid_take_s ? DMemRData : raw_q;

  lsu_load_align u_align (
    .raw_i    (align_raw_s),
    .funct3_i (f3_q),
    .off_i    (off_q),
    .data_o   (align_data_s)
  );

  // FSM next state and all combinational outputs
  always_comb begin
    state_d      = state_q;
    load_grant_s = 1'b0;
    DMemReq      = 1'b0;
    DMemWe       = 1'b0;
    DMemAddr     = '0;
    DMemBe       = BE_NONE;
    DMemWData    = '0;
    StallM       = 1'b0;
    ReadDataM    = align_data_s;
    if (!RSTn) begin
      // Outputs read as zero while reset is held.
      ReadDataM = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access_s && misalign_s) begin
            ReadDataM = '0;
          end else if (access_s) begin
            DMemReq   = 1'b1;
            DMemWe    = MemWriteM;
            DMemAddr  = {ALUResultM[WIDTH-1:2], 2'b00};
            DMemBe    = MemWriteM ? store_be_s : BE_WORD;
            DMemWData = MemWriteM ? store_wdata_s : '0;
            if (DMemGnt && MemReadM) begin
              StallM       = 1'b1;
              load_grant_s = 1'b1;
              state_d      = ST_WAIT;
            end else if (DMemGnt) begin
              StallM = 1'b0;
            end else begin
              StallM = 1'b1;
            end
          end else begin
            StallM = 1'b0;
          end
        end
        ST_WAIT: begin
          if (DMemRValid) begin
            StallM  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            StallM = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, captured load attributes and held raw load word
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      raw_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_grant_s) begin
        f3_q  <= Funct3M;
        off_q <= ALUResultM[1:0];
      end
      if (rvalid_take_s) begin
        raw_q <= DMemRData;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu -- directed self-checking bench for mem_stage_lsu.
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge. Expected values are hand-computed constants.
module tb_mem_stage_lsu;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
`ifdef LSU_MISALIGN_CHK_EN
  logic        MisalignM;
`endif
  logic        DMemReq, DMemWe;
  logic [31:0] DMemAddr;
  logic [3:0]  DMemBe;
  logic [31:0] DMemWData;
  logic        DMemGnt, DMemRValid;
  logic [31:0] DMemRData;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mem_stage_lsu #(.WIDTH(32)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
`ifdef LSU_MISALIGN_CHK_EN
    .MisalignM  (MisalignM),
`endif
    .DMemReq    (DMemReq),
    .DMemWe     (DMemWe),
    .DMemAddr   (DMemAddr),
    .DMemBe     (DMemBe),
    .DMemWData  (DMemWData),
    .DMemGnt    (DMemGnt),
    .DMemRValid (DMemRValid),
    .DMemRData  (DMemRData)
  );

  task automatic idle_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = 32'h0; WriteDataM = 32'h0;
    DMemGnt = 1'b0; DMemRValid = 1'b0; DMemRData = 32'h0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (DMemReq !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL reset_ctl req=%b stall=%b want 0 0", DMemReq, StallM); end
    checks++; if (ReadDataM !== 32'h0 || DMemAddr !== 32'h0 || DMemBe !== 4'h0 || DMemWData !== 32'h0 || DMemWe !== 1'b0) begin
      errors++; $display("FAIL reset_data rd=%h addr=%h be=%b wd=%h we=%b want zeros", ReadDataM, DMemAddr, DMemBe, DMemWData, DMemWe); end
`ifdef LSU_MISALIGN_CHK_EN
    checks++; if (MisalignM !== 1'b0) begin errors++; $display("FAIL reset_mis got=%b want 0", MisalignM); end
`endif
    @(posedge CLK); #1; RSTn = 1'b1;
    @(negedge CLK);
    checks++; if (DMemReq !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'h0) begin
      errors++; $display("FAIL idle_after_reset req=%b stall=%b rd=%h want 0 0 0", DMemReq, StallM, ReadDataM); end
  endtask

  task automatic test_store_byte();
    @(posedge CLK); #1;
    MemWriteM = 1'b1; Funct3M = 3'b000; ALUResultM = 32'h1003; WriteDataM = 32'h0000_00A5; DMemGnt = 1'b1;
    @(negedge CLK);
    checks++; if (DMemReq !== 1'b1 || DMemWe !== 1'b1 || StallM !== 1'b0) begin
      errors++; $display("FAIL sb_ctl req=%b we=%b stall=%b want 1 1 0", DMemReq, DMemWe, StallM); end
    checks++; if (DMemAddr !== 32'h1000 || DMemBe !== 4'b1000 || DMemWData !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL sb_bus addr=%h be=%b wd=%h want 00001000 1000 a5a5a5a5", DMemAddr, DMemBe, DMemWData); end
    @(posedge CLK); #1;
    MemWriteM = 1'b1; Funct3M = 3'b001; ALUResultM = 32'h1006; WriteDataM = 32'h1234_ABCD; DMemGnt = 1'b1;
    @(negedge CLK);
    checks++; if (DMemAddr !== 32'h1004 || DMemBe !== 4'b1100 || DMemWData !== 32'hABCD_ABCD || StallM !== 1'b0) begin
      errors++; $display("FAIL sh_bus addr=%h be=%b wd=%h stall=%b want 00001004 1100 abcdabcd 0", DMemAddr, DMemBe, DMemWData, StallM); end
    @(posedge CLK); #1; idle_inputs();
    @(negedge CLK);
    checks++; if (DMemReq !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL store_idle req=%b stall=%b want 0 0", DMemReq, StallM); end
  endtask

  task automatic test_store_wait();
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      MemWriteM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h4000; WriteDataM = 32'hDEAD_BEEF;
      DMemGnt = (c == 3);
      @(negedge CLK);
      checks++; if (DMemReq !== 1'b1 || DMemAddr !== 32'h4000 || DMemWData !== 32'hDEAD_BEEF || DMemBe !== 4'b1111) begin
        errors++; $display("FAIL sw_hold c=%0d req=%b addr=%h wd=%h be=%b want 1 00004000 deadbeef 1111", c, DMemReq, DMemAddr, DMemWData, DMemBe); end
      checks++; if (StallM !== (c != 3)) begin errors++; $display("FAIL sw_stall c=%0d got=%b want %b", c, StallM, (c != 3)); end
    end
    @(posedge CLK); #1; idle_inputs();
  endtask

  // Issue a load granted at once, rvalid k cycles later; check stall, result and hold
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] raw,
                         input int k, input logic [31:0] expd, input string name);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    @(posedge CLK); #1;
    MemReadM = 1'b1; Funct3M = f3; ALUResultM = addr; DMemGnt = 1'b1; DMemRValid = 1'b0;
    @(negedge CLK);
    checks++; if (DMemReq !== 1'b1 || DMemWe !== 1'b0 || StallM !== 1'b1 || DMemBe !== 4'b1111 || DMemAddr !== waddr) begin
      errors++; $display("FAIL %s_req req=%b we=%b stall=%b be=%b addr=%h want 1 0 1 1111 %h", name, DMemReq, DMemWe, StallM, DMemBe, DMemAddr, waddr); end
    for (int c = 1; c < k; c++) begin
      @(posedge CLK); #1; DMemGnt = 1'b0;
      @(negedge CLK);
      checks++; if (DMemReq !== 1'b0 || StallM !== 1'b1) begin
        errors++; $display("FAIL %s_wait c=%0d req=%b stall=%b want 0 1", name, c, DMemReq, StallM); end
    end
    @(posedge CLK); #1; DMemGnt = 1'b0; DMemRValid = 1'b1; DMemRData = raw;
    @(negedge CLK);
    checks++; if (StallM !== 1'b0 || ReadDataM !== expd) begin
      errors++; $display("FAIL %s_data stall=%b rd=%h want 0 %h", name, StallM, ReadDataM, expd); end
    @(posedge CLK); #1; MemReadM = 1'b0; DMemRValid = 1'b0; DMemRData = 32'h5A5A_5A5A;
    @(negedge CLK);
    checks++; if (StallM !== 1'b0 || DMemReq !== 1'b0 || ReadDataM !== expd) begin
      errors++; $display("FAIL %s_hold stall=%b req=%b rd=%h want 0 0 %h", name, StallM, DMemReq, ReadDataM, expd); end
  endtask

  task automatic test_load_byte();
    do_load(3'b000, 32'h2001, 32'h0000_8000, 2, 32'hFFFF_FF80, "lb");
    do_load(3'b100, 32'h2001, 32'h0000_8000, 2, 32'h0000_0080, "lbu");
    do_load(3'b000, 32'h2003, 32'h7F00_0000, 1, 32'h0000_007F, "lb_pos");
  endtask

  task automatic test_load_half();
    do_load(3'b101, 32'h2002, 32'hBEEF_1234, 1, 32'h0000_BEEF, "lhu");
    do_load(3'b001, 32'h2002, 32'hBEEF_1234, 3, 32'hFFFF_BEEF, "lh");
    do_load(3'b001, 32'h2000, 32'hBEEF_1234, 1, 32'h0000_1234, "lh_lo");
    do_load(3'b010, 32'h2000, 32'h8765_4321, 1, 32'h8765_4321, "lw");
    do_load(3'b011, 32'h2000, 32'h8765_4321, 1, 32'h0000_0000, "bad_f3");
  endtask

  task automatic test_reset_in_wait();
    do_load(3'b010, 32'h2000, 32'h1111_2222, 1, 32'h1111_2222, "pre_rst");
    @(posedge CLK); #1;
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h2000; DMemGnt = 1'b1;
    @(negedge CLK);
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL rst_wait_enter stall=%b want 1", StallM); end
    @(posedge CLK); #1; RSTn = 1'b0; idle_inputs();
    @(negedge CLK);
    checks++; if (DMemReq !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'h0) begin
      errors++; $display("FAIL rst_in_wait req=%b stall=%b rd=%h want 0 0 0", DMemReq, StallM, ReadDataM); end
    @(posedge CLK); #1; RSTn = 1'b1; DMemRValid = 1'b1; DMemRData = 32'h1234_5678;
    @(negedge CLK);
    checks++; if (StallM !== 1'b0 || ReadDataM !== 32'h0 || DMemReq !== 1'b0) begin
      errors++; $display("FAIL late_rvalid stall=%b rd=%h req=%b want 0 0 0", StallM, ReadDataM, DMemReq); end
    @(posedge CLK); #1; DMemRValid = 1'b0;
    @(negedge CLK);
    checks++; if (ReadDataM !== 32'h0 || StallM !== 1'b0) begin
      errors++; $display("FAIL late_rvalid_hold rd=%h stall=%b want 0 0", ReadDataM, StallM); end
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_CHK_EN
    @(posedge CLK); #1;
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h3002; DMemGnt = 1'b1;
    @(negedge CLK);
    checks++; if (DMemReq !== 1'b0 || MisalignM !== 1'b1 || StallM !== 1'b0 || ReadDataM !== 32'h0) begin
      errors++; $display("FAIL misalign req=%b mis=%b stall=%b rd=%h want 0 1 0 0", DMemReq, MisalignM, StallM, ReadDataM); end
    @(posedge CLK); #1; idle_inputs();
    @(negedge CLK);
    checks++; if (MisalignM !== 1'b0 || DMemReq !== 1'b0) begin
      errors++; $display("FAIL misalign_clear mis=%b req=%b want 0 0", MisalignM, DMemReq); end
`else
    do_load(3'b010, 32'h3002, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, "lw_unaligned");
`endif
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_store_wait();
    test_load_byte();
    test_load_half();
    test_reset_in_wait();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the memory stage of the pipelined RV32I core. It sits between the EX/MEM pipeline register and the MEM/WB register (`MemWriteff`). It turns the memory-stage control and address into a handshaked data-memory transaction, with byte enables and lane-replicated store data. It returns aligned, sign- or zero-extended load data as `ReadDataM`, and raises `StallM` to the hazard unit until the access completes.

## Interface
- `WIDTH`, default 32: data and address width. Only 32 is supported.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RSTn`  in  1  synchronous, active-low reset.
- `MemReadM`  in  1  load in the memory stage.
- `MemWriteM`  in  1  store in the memory stage. Never asserted together with `MemReadM`.
- `Funct3M`  in  3  access size and sign (RV32I load/store funct3).
- `ALUResultM`  in  WIDTH  effective byte address.
- `WriteDataM`  in  WIDTH  store source register value.
- `ReadDataM`  out  WIDTH  formatted load data, consumed by `MemWriteff`.
- `StallM`  out  1  freeze the IF through EX/MEM registers this cycle.
- `MisalignM`  out  1  misaligned access flagged. Present only with the macro.
- `DMemReq`  out  1  request valid.
- `DMemWe`  out  1  1 = store.
- `DMemAddr`  out  WIDTH  word address; bits [1:0] are always 0.
- `DMemBe`  out  4  byte enables.
- `DMemWData`  out  WIDTH  lane-replicated store data.
- `DMemGnt`  in  1  request accepted this cycle.
- `DMemRValid`  in  1  load data valid. Earliest is 1 cycle after the grant.
- `DMemRData`  in  WIDTH  raw load word.

## Operation
- FSM states: IDLE and WAIT.
- **IDLE with no access:**
  - `DMemReq`=0 and `StallM`=0.
  - `ReadDataM` holds the last load result.
- **IDLE with an access:**
  - `DMemReq`=1 combinationally, and stays asserted until `DMemGnt`.
  - No grant: stay in IDLE with `StallM`=1.
  - Store granted: the access is complete, `StallM`=0, stay in IDLE.
  - Load granted: `StallM`=1. Capture `Funct3M` and `ALUResultM[1:0]` into registers, then go to WAIT.
- **WAIT:**
  - `DMemReq`=0.
  - `StallM`=1 until `DMemRValid`.
  - On `DMemRValid`: `ReadDataM` = formatted `DMemRData` (combinational), `StallM`=0, and the raw word is registered for hold. Return to IDLE.
- Store byte enables, by size, with off = `ALUResultM[1:0]`:
  - SB (000): `0001<<off`, data `{4{WriteDataM[7:0]}}`.
  - SH (001): `0011<<{off[1],0}`, data `{2{WriteDataM[15:0]}}`.
  - SW (010): `1111`, data `WriteDataM`.
- Load `DMemBe` is `1111`; formatting happens inside the unit.
- Load formatting selects the byte or halfword lane by the captured offset, then extends:
  - LB and LH (000, 001) sign-extend.
  - LBU and LHU (100, 101) zero-extend.
  - LW (010) passes the word through.
  - Any other funct3 yields 0.
- Reset mid-transaction: return to IDLE and drop `DMemReq`. Any `DMemRValid` after reset is ignored; the memory is reset with the core.
- A second grant while in WAIT is impossible, because `DMemReq` is low in WAIT.

## Timing
- Reset values:
  - state = IDLE.
  - `ReadDataM`, `DMemReq`, `DMemWe`, `DMemBe`, `DMemAddr`, `DMemWData`, `StallM` and `MisalignM` all = 0.
  - Captured registers = 0.
- Store with immediate grant: zero stall cycles.
- Load with grant in cycle N and rvalid in cycle N+k (k≥1): `StallM` is high in cycles N through N+k−1. Data is captured by MEM/WB at the end of cycle N+k.
- Each grant-wait cycle adds one stall cycle.

## Configuration
- `LSU_MISALIGN_CHK_EN` defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]≠0, issues no request.
  - `MisalignM`=1 for that cycle, `StallM`=0, `ReadDataM`=0. The store is dropped.
- Not defined:
  - The `MisalignM` port is absent.
  - Offending low address bits are ignored: halfword uses addr[1] only, word is forced aligned.

## Structure
- `lsu_pkg` holds:
  - The funct3 enum (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - The FSM state enum.
  - The byte-enable constants.
- Sub-module `lsu_load_align` contains the purely combinational lane select and extension (raw word, funct3, offset → `ReadDataM`).

## Test plan
- SB of `WriteDataM`=0x000000A5 to 0x1003 with immediate grant → `DMemAddr`=0x1000, `DMemBe`=1000, `DMemWData`=0xA5A5A5A5, `StallM` never high.
- LB from 0x2001, raw word 0x0000_8000, grant in cycle 0, rvalid in cycle 2 → `StallM` high in cycles 0–1, `ReadDataM`=0xFFFFFF80 in cycle 2. The same word read with LBU gives 0x00000080.
- LHU from 0x2002, raw word 0xBEEF1234 → 0x0000BEEF; LH gives 0xFFFFBEEF.
- Store with `DMemGnt` low for 3 cycles → `DMemReq` and stable address/data held for 4 cycles, `StallM` high for 3.
- `RSTn` low while in WAIT, followed by a late rvalid → state IDLE, `ReadDataM`=0, no stall.
- With the macro, LW at 0x3002 → no `DMemReq`, `MisalignM`=1 for one cycle. Without the macro, the same access reads 0x3000.
